// File: rtl/hit_window_latch.sv
// Multi-channel scintillator hit latch: synchronises discriminator inputs, gathers
// all hits inside a coincidence window and offers them as one event word.
module hit_window_latch #(
  parameter int N_CH            = 24,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_MODE       = 1,
  parameter int WINDOW_CYCLES   = 4,
  parameter int DEADTIME_CYCLES = 8,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   hit_in,
  input  logic              clear,
  input  logic              evt_ready,
  output logic              evt_valid,
  output logic [N_CH-1:0]   evt_hits,
  output logic [CNT_W-1:0]  evt_count,
  output logic [CNT_W-1:0]  missed_count,
  output logic              busy
);

  localparam int WCNT_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int DCNT_W = (DEADTIME_CYCLES > 1) ? $clog2(DEADTIME_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WLOAD = WCNT_W'(WINDOW_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DLOAD = DCNT_W'((DEADTIME_CYCLES > 0) ? DEADTIME_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WINDOW  = 2'd1,
    READOUT = 2'd2,
    DEAD    = 2'd3
  } state_t;

  logic [N_CH-1:0]   sync_q [SYNC_STAGES];
  logic [N_CH-1:0]   prev_q;
  logic [N_CH-1:0]   hit_q, hit_d;
  logic [N_CH-1:0]   sync_out;

  state_t            state_q, state_d;
  logic [N_CH-1:0]   latch_q, latch_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0]  evt_count_q, evt_count_d;
  logic [CNT_W-1:0]  missed_q, missed_d;
  logic              evt_valid_q, evt_valid_d;
  logic              busy_q, busy_d;
  logic              any_hit;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // The hit vector is registered once more so every channel reaches the latch
  // on a clean flop boundary, giving SYNC_STAGES+1 cycles of input latency.
  always_comb begin
    hit_d = (EDGE_MODE != 0) ? (sync_out & ~prev_q) : sync_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      hit_q  <= '0;
    end else begin
      sync_q[0] <= hit_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_out;
      hit_q  <= hit_d;
    end
  end

  assign any_hit = |hit_q;

  always_comb begin
    state_d     = state_q;
    latch_d     = latch_q;
    wcnt_d      = wcnt_q;
    dcnt_d      = dcnt_q;
    evt_count_d = evt_count_q;
    missed_d    = missed_q;

    case (state_q)
      IDLE: begin
        if (any_hit) begin
          latch_d = hit_q;
          wcnt_d  = WLOAD;
          state_d = WINDOW;
        end
      end
      WINDOW: begin
        latch_d = latch_q | hit_q;
        if (wcnt_q == '0) state_d = READOUT;
        else              wcnt_d  = wcnt_q - WCNT_W'(1);
      end
      READOUT: begin
        if (any_hit && (missed_q != '1)) missed_d = missed_q + CNT_W'(1);
        if (evt_ready) begin
          if (evt_count_q != '1) evt_count_d = evt_count_q + CNT_W'(1);
          latch_d = '0;
          if (DEADTIME_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = DEAD;
            dcnt_d  = DLOAD;
          end
        end
      end
      DEAD: begin
        if (any_hit && (missed_q != '1)) missed_d = missed_q + CNT_W'(1);
        if (dcnt_q == '0) state_d = IDLE;
        else              dcnt_d  = dcnt_q - DCNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Soft clear overrides any trigger or handshake on the same edge.
    if (clear) begin
      state_d     = IDLE;
      latch_d     = '0;
      wcnt_d      = '0;
      dcnt_d      = '0;
      evt_count_d = '0;
      missed_d    = '0;
    end

    evt_valid_d = (state_d == READOUT);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      latch_q     <= '0;
      wcnt_q      <= '0;
      dcnt_q      <= '0;
      evt_count_q <= '0;
      missed_q    <= '0;
      evt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      latch_q     <= latch_d;
      wcnt_q      <= wcnt_d;
      dcnt_q      <= dcnt_d;
      evt_count_q <= evt_count_d;
      missed_q    <= missed_d;
      evt_valid_q <= evt_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign evt_valid    = evt_valid_q;
  assign evt_hits     = latch_q;
  assign evt_count    = evt_count_q;
  assign missed_count = missed_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_hit_window_latch.sv
// Bench for hit_window_latch: an event-level reference model feeds a scoreboard that
// a negedge monitor drains; a second small-counter, level-mode instance covers saturation.
module tb_hit_window_latch;

  localparam int N_CH = 24;
  localparam int W    = 4;
  localparam int D    = 8;
  localparam int CMAX = 65535;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_CH-1:0]   hit_in;
  logic              clear;
  logic              evt_ready;
  logic              evt_valid;
  logic [N_CH-1:0]   evt_hits;
  logic [15:0]       evt_count;
  logic [15:0]       missed_count;
  logic              busy;

  logic [N_CH-1:0]   hit_in_b;
  logic              clear_b;
  logic              evt_ready_b;
  logic              evt_valid_b;
  logic [N_CH-1:0]   evt_hits_b;
  logic [3:0]        evt_count_b;
  logic [3:0]        missed_count_b;
  logic              busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hit_window_latch dut (
    .clk(clk), .rst_n(rst_n), .hit_in(hit_in), .clear(clear), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_hits(evt_hits), .evt_count(evt_count),
    .missed_count(missed_count), .busy(busy)
  );

  hit_window_latch #(
    .N_CH(N_CH), .SYNC_STAGES(2), .EDGE_MODE(0), .WINDOW_CYCLES(1),
    .DEADTIME_CYCLES(0), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .hit_in(hit_in_b), .clear(clear_b), .evt_ready(evt_ready_b),
    .evt_valid(evt_valid_b), .evt_hits(evt_hits_b), .evt_count(evt_count_b),
    .missed_count(missed_count_b), .busy(busy_b)
  );

  task automatic checkOutput(input string name, input longint unsigned actual,
                             input longint unsigned expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: a hit sampled at edge k is seen by the event logic at edge k+3;
  // window, readout and dead phases are tracked with absolute edge deadlines.
  logic [N_CH-1:0] samp [4];
  logic [N_CH-1:0] m_latch;
  logic [N_CH-1:0] sb [$];
  int              m_phase;
  int              edge_no;
  int              win_end;
  int              dead_end;
  int unsigned     m_cnt;
  int unsigned     m_missed;

  initial begin
    logic [N_CH-1:0] h;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) samp[i] = '0;
        m_latch = '0; m_phase = 0; edge_no = 0; win_end = 0; dead_end = 0;
        m_cnt = 0; m_missed = 0;
        sb.delete();
      end else begin
        edge_no++;
        h = samp[2] & ~samp[3];
        samp[3] = samp[2]; samp[2] = samp[1]; samp[1] = samp[0]; samp[0] = hit_in;
        if (clear) begin
          m_phase = 0; m_latch = '0; m_cnt = 0; m_missed = 0;
          sb.delete();
        end else begin
          case (m_phase)
            0: if (h != '0) begin
                 m_latch = h; win_end = edge_no + W; m_phase = 1;
               end
            1: begin
                 m_latch |= h;
                 if (edge_no == win_end) begin
                   m_phase = 2;
                   sb.push_back(m_latch);
                 end
               end
            2: begin
                 if (h != '0 && m_missed < CMAX) m_missed++;
                 if (evt_ready) begin
                   if (m_cnt < CMAX) m_cnt++;
                   m_latch = '0; dead_end = edge_no + D; m_phase = 3;
                 end
               end
            default: begin
                 if (h != '0 && m_missed < CMAX) m_missed++;
                 if (edge_no == dead_end) m_phase = 0;
               end
          endcase
        end
      end
    end
  end

  // Monitor: per-cycle status against the model, and event words against the scoreboard.
  initial begin
    logic [N_CH-1:0] exp_hits;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checkOutput("evt_valid", evt_valid, (m_phase == 2) ? 1 : 0);
        checkOutput("busy", busy, (m_phase != 0) ? 1 : 0);
        checkOutput("evt_count", evt_count, m_cnt);
        checkOutput("missed_count", missed_count, m_missed);
        if (m_phase == 2) checkOutput("evt_hits_held", evt_hits, m_latch);
        if (evt_valid && evt_ready && !clear) begin
          if (sb.size() == 0) begin
            checkOutput("sb_unexpected_event", 1, 0);
          end else begin
            exp_hits = sb.pop_front();
            checkOutput("sb_event_hits", evt_hits, exp_hits);
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [N_CH-1:0] hv, input logic rdy, input logic clr);
    @(posedge clk);
    #2;
    hit_in = hv; evt_ready = rdy; clear = clr;
  endtask

  task automatic applyStimulusB(input logic [N_CH-1:0] hv, input logic rdy, input logic clr);
    @(posedge clk);
    #2;
    hit_in_b = hv; evt_ready_b = rdy; clear_b = clr;
  endtask

  task automatic idleCycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus('0, rdy, 1'b0);
  endtask

  task automatic waitValid(input string name, input int budget);
    int n;
    n = 0;
    while (!evt_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!evt_valid) begin
      errors++;
      $display("[TB] FAIL %s: evt_valid still 0 after %0d cycles, required 1", name, budget);
    end
  endtask

  initial begin
    int unsigned c0, m0;
    logic [N_CH-1:0] hv;
    int r;

    rst_n = 1'b0; hit_in = '0; clear = 1'b0; evt_ready = 1'b1;
    hit_in_b = '0; clear_b = 1'b0; evt_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_evt_valid", evt_valid, 0);
    checkOutput("reset_evt_hits", evt_hits, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_evt_count", evt_count, 0);
    @(posedge clk); #2; rst_n = 1'b1;

    // Single pulse on channel 3.
    idleCycles(5, 1'b1);
    applyStimulus(24'h000008, 1'b1, 1'b0);
    idleCycles(25, 1'b1);
    @(negedge clk);
    checkOutput("t1_evt_count", evt_count, 1);
    checkOutput("t1_missed", missed_count, 0);

    // Channel 23 three edges after channel 0: inside the window.
    c0 = evt_count; m0 = missed_count;
    applyStimulus(24'h000001, 1'b1, 1'b0);
    idleCycles(2, 1'b1);
    applyStimulus(24'h800000, 1'b1, 1'b0);
    idleCycles(25, 1'b1);
    @(negedge clk);
    checkOutput("t2_evt_delta", evt_count - c0, 1);
    checkOutput("t2_missed_delta", missed_count - m0, 0);

    // Channel 23 eight edges after channel 0: lands in dead time.
    c0 = evt_count; m0 = missed_count;
    applyStimulus(24'h000001, 1'b1, 1'b0);
    idleCycles(7, 1'b1);
    applyStimulus(24'h800000, 1'b1, 1'b0);
    idleCycles(25, 1'b1);
    @(negedge clk);
    checkOutput("t3_evt_delta", evt_count - c0, 1);
    checkOutput("t3_missed_delta", missed_count - m0, 1);

    // Backpressure with three pulses while the event waits.
    c0 = evt_count; m0 = missed_count;
    applyStimulus(24'h000080, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    waitValid("bp_wait_valid", 40);
    for (int i = 0; i < 30; i++)
      applyStimulus((i == 5 || i == 12 || i == 20) ? 24'h000080 : 24'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp_valid_held", evt_valid, 1);
    checkOutput("bp_hits_held", evt_hits, 24'h000080);
    checkOutput("bp_missed_delta", missed_count - m0, 3);
    idleCycles(15, 1'b1);
    @(negedge clk);
    checkOutput("bp_evt_delta", evt_count - c0, 1);

    // Held input in edge mode gives one event only.
    c0 = evt_count; m0 = missed_count;
    for (int i = 0; i < 50; i++) applyStimulus(24'h000020, 1'b1, 1'b0);
    idleCycles(20, 1'b1);
    @(negedge clk);
    checkOutput("hold_evt_delta", evt_count - c0, 1);
    checkOutput("hold_missed_delta", missed_count - m0, 0);

    // Soft clear while an event is pending.
    applyStimulus(24'h000004, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    waitValid("clr_wait_valid", 40);
    applyStimulus('0, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("clr_evt_valid", evt_valid, 0);
    checkOutput("clr_busy", busy, 0);
    checkOutput("clr_evt_count", evt_count, 0);
    checkOutput("clr_missed", missed_count, 0);
    idleCycles(3, 1'b1);

    // Asynchronous reset in the middle of the window.
    applyStimulus(24'h000200, 1'b1, 1'b0);
    idleCycles(4, 1'b1);
    checkOutput("areset_busy_before", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("areset_evt_valid", evt_valid, 0);
    checkOutput("areset_evt_hits", evt_hits, 0);
    checkOutput("areset_busy", busy, 0);
    checkOutput("areset_evt_count", evt_count, 0);
    checkOutput("areset_missed", missed_count, 0);
    @(posedge clk); #2; rst_n = 1'b1;
    idleCycles(5, 1'b1);

    // Random traffic with random backpressure and occasional clears.
    hv = '0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10)      hv = 24'(1) << $urandom_range(0, 23);
      else if (r < 13) hv = 24'($urandom) & 24'($urandom);
      else if (r >= 20) hv = '0;
      applyStimulus(hv, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
    end
    idleCycles(40, 1'b1);
    @(negedge clk);
    checkOutput("sb_drained", sb.size(), 0);

    // Small-counter, level-mode, zero-dead-time instance: saturation.
    for (int i = 1; i <= 17; i++) begin
      applyStimulusB(24'(1) << (i % 24), 1'b1, 1'b0);
      repeat (7) applyStimulusB('0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("sat_evt_count_%0d", i), evt_count_b, (i > 15) ? 15 : i);
    end
    checkOutput("sat_missed_b", missed_count_b, 0);

    // Level mode retriggers while the input stays high.
    applyStimulusB('0, 1'b1, 1'b1);
    applyStimulusB('0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("b_clear_count", evt_count_b, 0);
    repeat (12) applyStimulusB(24'h000010, 1'b1, 1'b0);
    repeat (10) applyStimulusB('0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (evt_count_b < 2) begin
      errors++;
      $display("[TB] FAIL level_retrigger: got %0d events, required at least 2", evt_count_b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hit_window_latch.md
Name: hit_window_latch

Overview:
- Parametrised successor to the per-channel scintillator hit latch.
- Synchronises N_CH asynchronous discriminator inputs and detects rising edges per channel.
- Collects all channel hits within a fixed coincidence window after the first hit, then presents them as one event word on a valid/ready interface.
- Applies a programmable dead time after readout; keeps saturating event and missed-hit counters for the readout logic.

Parameters:
N_CH, 24, number of hit channels
SYNC_STAGES, 2, synchroniser depth per channel (>=2)
EDGE_MODE, 1, 1 = trigger on synchronised rising edge; 0 = trigger on synchronised high level
WINDOW_CYCLES, 4, coincidence window length in clk cycles after trigger (>=1)
DEADTIME_CYCLES, 8, dead cycles after event accept (0 = none)
CNT_W, 16, width of event and missed counters

Ports:
clk  in  1  system clock (PLL output)
rst_n  in  1  asynchronous active-low reset
hit_in  in  N_CH  asynchronous discriminator inputs
clear  in  1  synchronous soft clear
evt_ready  in  1  consumer ready
evt_valid  out  1  event word available
evt_hits  out  N_CH  latched hit pattern
evt_count  out  CNT_W  accepted events, saturating
missed_count  out  CNT_W  cycles with rejected hits, saturating
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous) clears all outputs, sync chains, edge history, counters and state to 0 / IDLE.
- Sync chain: hit_in passes through SYNC_STAGES flops to give s. The edge register p <= s runs every cycle in every state.
- Hit vector h:
  - EDGE_MODE=1: h = s & ~p.
  - EDGE_MODE=0: h = s.
- Latency: a hit_in high sampled at edge k sets its latch bit at edge k+SYNC_STAGES+1.
- States: IDLE, WINDOW, READOUT, DEAD.
- IDLE:
  - If |h, then latch <= h, wcnt <= WINDOW_CYCLES-1, and state moves to WINDOW.
- WINDOW:
  - latch <= latch | h on every edge, including the final edge.
  - If wcnt==0, move to READOUT; else decrement wcnt.
  - Net effect: hits on the trigger edge plus the next WINDOW_CYCLES edges are captured.
- READOUT:
  - evt_valid=1; evt_hits is held constant (it is the latch register).
  - The latch ignores h.
  - On evt_valid&evt_ready:
    - evt_count increments (saturating at all ones).
    - latch clears.
    - state moves to DEAD with dcnt <= DEADTIME_CYCLES-1, or to IDLE directly if DEADTIME_CYCLES==0.
  - evt_valid is registered and drops on the accept edge.
- DEAD:
  - Ignores h.
  - If dcnt==0, move to IDLE; else decrement dcnt.
- missed_count increments by 1 (saturating) on each edge where |h and state is READOUT or DEAD.
- Simultaneous trigger and clear: clear wins.
- clear (priority over all except reset):
  - Next edge: latch=0, state=IDLE, evt_valid=0, evt_count=0, missed_count=0.
  - Sync chain and p are not cleared.
- In edge mode, an input held high through READOUT/DEAD does not retrigger on return to IDLE.
- In level mode, it retriggers immediately.
- evt_valid and evt_hits never change while evt_valid=1 without a handshake, clear or reset.
- busy=1 in WINDOW, READOUT, DEAD.
- All outputs registered.

Test Plan:
- Defaults, evt_ready=1, hit_in[3] high for one cycle at edge 10.
  - Latch set at edge 13, evt_valid=1 after edge 17 with evt_hits=0x000008.
  - Accepted at edge 18: evt_count=1, busy drops after edge 26.
- hit_in[0] pulse at edge 10, hit_in[23] pulse at edge 13 -> evt_hits=0x800001, missed_count=0.
- Repeat with hit_in[23] at edge 18 instead of 13 -> evt_hits=0x000001, missed_count=1, no second event.
- Backpressure: evt_ready=0 for 30 cycles after evt_valid, with 3 single-cycle pulses on hit_in[7] during that time.
  - evt_valid stays 1 and evt_hits stays unchanged throughout.
  - missed_count=3.
  - evt_count=1 after evt_ready rises.
- Held input: hit_in[5] high for 50 cycles, EDGE_MODE=1 -> exactly one event (evt_count=1), missed_count=0.
- Soft clear: clear pulsed while evt_valid=1 -> next edge evt_valid=0, state IDLE, evt_count=0.
- Async reset: rst_n low mid-WINDOW -> all outputs 0 before the next clk edge.
- Saturation: CNT_W=4, 17 accepted events -> evt_count=15.
